// File: rtl/axi_mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_resp_pkg
// Shared definitions for the AXI4 on-chip memory responder:
//   - AXI response codes
//   - beat geometry (64-byte beats)
//   - bus field widths
//   - write/read FSM state enums
//   - the read-FIFO entry layout
// ---------------------------------------------------------------------------
package axi_mem_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BEAT_BYTES = 64;
    localparam int BEAT_LSB   = 6;

    localparam int ADDR_W = 64;
    localparam int DATA_W = BEAT_BYTES * 8;
    localparam int ID_W   = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } rd_entry_t;

endpackage

// File: rtl/axi_bus_t.sv
// ---------------------------------------------------------------------------
// axi_bus_t
// AXI4 link bundle (INCR bursts, 64-byte beats).
//   - modport master: the responder end. aw*/w*/ar*/bready/rready are
//     inputs; awready/wready/b*/arready/r* are outputs.
//   - modport initiator: the mirror of master, for the driving side.
// ---------------------------------------------------------------------------
interface axi_bus_t;
    import axi_mem_resp_pkg::*;

    // Write address channel
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [LEN_W-1:0]      awlen;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;

    // Write data channel
    logic [ID_W-1:0]       wid;
    logic [DATA_W-1:0]     wdata;
    logic [BEAT_BYTES-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    // Write response channel
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    // Read address channel
    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [LEN_W-1:0]      arlen;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;

    // Read data channel
    logic [ID_W-1:0]       rid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arvalid,
        input  rready,
        output awready, wready,
        output bid, bresp, bvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid
    );

    modport initiator (
        output awid, awaddr, awlen, awsize, awvalid,
        output wid, wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arvalid,
        output rready,
        input  awready, wready,
        input  bid, bresp, bvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_mem_resp_fifo2.sv
// ---------------------------------------------------------------------------
// axi_mem_resp_fifo2
// Two-entry FIFO holding read beats for the R channel. The head entry stays
// stable until it is popped.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   push, din write one entry
//   pop       retire the head entry
//   dout      head entry
//   count     occupancy (0..2), used by the caller for read-issue credit
// ---------------------------------------------------------------------------
module axi_mem_resp_fifo2
    import axi_mem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rd_entry_t  din,
    input  logic       pop,
    output rd_entry_t  dout,
    output logic [1:0] count
);

    rd_entry_t  slot_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;

    // Storage, pointers and occupancy.
    // The caller never pushes into a full FIFO or pops an empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r[0] <= '0;
            slot_r[1] <= '0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            if (push) begin
                slot_r[wr_ptr_r] <= din;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = slot_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
// AXI4 responder backed by an on-chip RAM that is 512 bits (one 64-byte beat)
// wide. Write and read channels are independent; each channel handles one
// INCR burst at a time.
//
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   axi           responder end of the AXI link (axi_bus_t.master)
//   wr_burst_cnt  completed write bursts (counted on the B handshake); wraps
//   rd_burst_cnt  completed read bursts (counted on the rlast handshake); wraps
//   proto_err     sticky flag: wlast disagreed with awlen
//
// RAM index = addr[63:6] + beat.
//   - Default build: the index wraps modulo MEM_DEPTH, and every response
//     is OKAY.
//   - Macro AXI_MEM_RESP_ERR_EN: beats at index >= MEM_DEPTH are out of
//     range. Out-of-range writes are dropped and the burst gets
//     bresp=SLVERR. Out-of-range reads return zero data with rresp=SLVERR
//     on that beat.
// ---------------------------------------------------------------------------
module axi_mem_responder
    import axi_mem_resp_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    axi_bus_t.master         axi,
    output logic [CNT_W-1:0] wr_burst_cnt,
    output logic [CNT_W-1:0] rd_burst_cnt,
    output logic             proto_err
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int FULL_W = ADDR_W - BEAT_LSB;

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    // ---------------- Write side signals ----------------
    wr_state_t         wr_state_r;
    logic [ID_W-1:0]   aw_id_r;
    logic [FULL_W-1:0] aw_base_r;
    logic [LEN_W-1:0]  aw_len_r;
    logic [LEN_W-1:0]  wbeat_r;
    logic              awready_r;
    logic              wready_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic              wr_err_r;
    logic              proto_err_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic              w_hs_s;
    logic              w_last_beat_s;
    logic              w_oor_s;
    logic              we_s;
    logic [FULL_W-1:0] w_full_idx_s;
    logic [IDX_W-1:0]  w_idx_s;

    // ---------------- Read side signals ----------------
    rd_state_t         rd_state_r;
    logic [ID_W-1:0]   ar_id_r;
    logic [FULL_W-1:0] ar_base_r;
    logic [LEN_W-1:0]  ar_len_r;
    logic [LEN_W-1:0]  ibeat_r;
    logic              issuing_r;
    logic              arready_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              inflight_oor_r;
    logic [DATA_W-1:0] ram_q_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic              issue_s;
    logic              r_pop_s;
    logic              r_oor_s;
    logic [2:0]        credit_s;
    logic [FULL_W-1:0] r_full_idx_s;
    logic [IDX_W-1:0]  r_idx_s;
    logic [1:0]        fifo_count_s;
    rd_entry_t         fifo_din_s;
    rd_entry_t         fifo_head_s;
    logic              unused_s;

    assign w_hs_s        = axi.wvalid && wready_r;
    assign w_last_beat_s = (wbeat_r == aw_len_r);
    assign w_full_idx_s  = aw_base_r + FULL_W'(wbeat_r);
    assign w_idx_s       = w_full_idx_s[IDX_W-1:0];
    assign r_full_idx_s  = ar_base_r + FULL_W'(ibeat_r);
    assign r_idx_s       = r_full_idx_s[IDX_W-1:0];

`ifdef AXI_MEM_RESP_ERR_EN
    assign w_oor_s = (w_full_idx_s >= FULL_W'(MEM_DEPTH));
    assign r_oor_s = (r_full_idx_s >= FULL_W'(MEM_DEPTH));
`else
    assign w_oor_s = 1'b0;
    assign r_oor_s = 1'b0;
`endif

    // Out-of-range write beats are dropped rather than aliased.
    assign we_s = w_hs_s && !w_oor_s;

    // Write FSM: accept AW, count beats (the count is authoritative over
    // wlast), then hold the B response until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_r  <= W_IDLE;
            aw_id_r     <= {ID_W{1'b0}};
            aw_base_r   <= {FULL_W{1'b0}};
            aw_len_r    <= 8'd0;
            wbeat_r     <= 8'd0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            wr_err_r    <= 1'b0;
            proto_err_r <= 1'b0;
            wr_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    awready_r <= 1'b1;
                    if (axi.awvalid && awready_r) begin
                        aw_id_r    <= axi.awid;
                        aw_base_r  <= axi.awaddr[ADDR_W-1:BEAT_LSB];
                        aw_len_r   <= axi.awlen;
                        wbeat_r    <= 8'd0;
                        wr_err_r   <= 1'b0;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b1;
                        wr_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        wbeat_r <= wbeat_r + 8'd1;
                        if (axi.wlast != w_last_beat_s) begin
                            proto_err_r <= 1'b1;
                        end
                        if (w_oor_s) begin
                            wr_err_r <= 1'b1;
                        end
                        if (w_last_beat_s) begin
                            wready_r   <= 1'b0;
                            bvalid_r   <= 1'b1;
                            bresp_r    <= (wr_err_r || w_oor_s) ? RESP_SLVERR : RESP_OKAY;
                            wr_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_r   <= 1'b0;
                        wr_cnt_r   <= wr_cnt_r + CNT_W'(1'b1);
                        awready_r  <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // RAM: byte-enabled write port plus a registered read port.
    // Because both ports use non-blocking assignments, a read and a write to
    // the same index in one cycle returns the old data.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (axi.wstrb[i]) begin
                    mem_r[w_idx_s][i*8 +: 8] <= axi.wdata[i*8 +: 8];
                end
            end
        end
        if (issue_s) begin
            ram_q_r <= mem_r[r_idx_s];
        end
    end

    assign r_pop_s = (fifo_count_s != 2'd0) && axi.rready;

    // Read-issue credit.
    // A beat popped this cycle frees its slot, so it is returned as credit
    // straight away; this keeps a 1 beat/cycle stream going with only two
    // entries of buffering.
    always_comb begin
        credit_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, r_pop_s};
        if (issuing_r && (credit_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Build the FIFO entry for a RAM word returning this cycle.
    always_comb begin
        fifo_din_s.data = inflight_oor_r ? {DATA_W{1'b0}} : ram_q_r;
        fifo_din_s.resp = inflight_oor_r ? RESP_SLVERR : RESP_OKAY;
        fifo_din_s.last = inflight_last_r;
    end

    // Read FSM: accept AR, issue RAM reads against the FIFO credit, and
    // finish on the rlast handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r      <= R_IDLE;
            ar_id_r         <= {ID_W{1'b0}};
            ar_base_r       <= {FULL_W{1'b0}};
            ar_len_r        <= 8'd0;
            ibeat_r         <= 8'd0;
            issuing_r       <= 1'b0;
            arready_r       <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            inflight_oor_r  <= 1'b0;
            rd_cnt_r        <= {CNT_W{1'b0}};
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= (ibeat_r == ar_len_r);
            inflight_oor_r  <= r_oor_s;
            case (rd_state_r)
                R_IDLE: begin
                    arready_r <= 1'b1;
                    if (axi.arvalid && arready_r) begin
                        ar_id_r    <= axi.arid;
                        ar_base_r  <= axi.araddr[ADDR_W-1:BEAT_LSB];
                        ar_len_r   <= axi.arlen;
                        ibeat_r    <= 8'd0;
                        issuing_r  <= 1'b1;
                        arready_r  <= 1'b0;
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (issue_s) begin
                        ibeat_r <= ibeat_r + 8'd1;
                        if (ibeat_r == ar_len_r) begin
                            issuing_r <= 1'b0;
                        end
                    end
                    if (r_pop_s && fifo_head_s.last) begin
                        rd_cnt_r   <= rd_cnt_r + CNT_W'(1'b1);
                        arready_r  <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    axi_mem_resp_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .din   (fifo_din_s),
        .pop   (r_pop_s),
        .dout  (fifo_head_s),
        .count (fifo_count_s)
    );

    assign axi.awready = awready_r;
    assign axi.wready  = wready_r;
    assign axi.bvalid  = bvalid_r;
    assign axi.bid     = aw_id_r;
    assign axi.bresp   = bresp_r;
    assign axi.arready = arready_r;
    assign axi.rvalid  = (fifo_count_s != 2'd0);
    assign axi.rid     = ar_id_r;
    assign axi.rdata   = fifo_head_s.data;
    assign axi.rresp   = fifo_head_s.resp;
    assign axi.rlast   = fifo_head_s.last;

    assign wr_burst_cnt = wr_cnt_r;
    assign rd_burst_cnt = rd_cnt_r;
    assign proto_err    = proto_err_r;

    // Fields this responder does not use: beat size is fixed, wid is
    // ignored, and the sub-beat address bits carry no meaning.
    assign unused_s = ^{axi.awsize, axi.arsize, axi.wid,
                        axi.awaddr[BEAT_LSB-1:0], axi.araddr[BEAT_LSB-1:0],
                        w_full_idx_s, r_full_idx_s};

endmodule

// File: tb/tb_axi_mem_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_axi_mem_responder
// Scoreboard bench for axi_mem_responder.
//   - Expected B responses and R beats are queued when a burst is issued,
//     taken from a bench-side memory model.
//   - Queued entries are popped and compared as the DUT responds.
//   - The same bench works with or without AXI_MEM_RESP_ERR_EN.
// ---------------------------------------------------------------------------
module tb_axi_mem_responder;
    import axi_mem_resp_pkg::*;

    localparam int DEPTH = 1024;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] wr_burst_cnt;
    logic [CW-1:0] rd_burst_cnt;
    logic          proto_err;

    axi_bus_t bus();

    axi_mem_responder #(.MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .axi          (bus),
        .wr_burst_cnt (wr_burst_cnt),
        .rd_burst_cnt (rd_burst_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int           n_chk     = 0;
    int           n_err     = 0;
    int           exp_wr    = 0;
    int           exp_rd    = 0;
    logic         exp_proto = 1'b0;
    logic [511:0] model [DEPTH];
    rd_entry_t    rq [$];
    logic [9:0]   bq [$];

    // Count one comparison; report it if observed and expected differ.
    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Incrementing-byte beat pattern.
    function automatic logic [511:0] pat(input int seed, input int beat);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(seed + beat * 64 + i);
        return r;
    endfunction

    // Model of the RAM index mapping.
    function automatic void idx_of(input logic [63:0] addr, input int beat,
                                   output int idx, output bit oor);
        logic [57:0] full;
        full = addr[63:6] + 58'(beat);
`ifdef AXI_MEM_RESP_ERR_EN
        oor = (full >= 58'(DEPTH));
        idx = oor ? 0 : int'(full);
`else
        oor = 1'b0;
        idx = int'(full % 58'(DEPTH));
`endif
    endfunction

    // Present an AW request and complete its handshake.
    task automatic do_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin step(); n++; end
        chk("awready", bus.awready, 1'b1);
        step();
        bus.awvalid = 1'b0;
        chk("awready_drop", bus.awready, 1'b0);
    endtask

    // Present one W beat, complete its handshake and update the model.
    task automatic do_wbeat(input logic [63:0] addr, input int b, input logic [511:0] d,
                            input logic [63:0] strb, input logic last);
        int n = 0;
        int idx;
        bit oor;
        bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin step(); n++; end
        chk("wready", bus.wready, 1'b1);
        step();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        idx_of(addr, b, idx, oor);
        if (!oor) begin
            for (int i = 0; i < 64; i++) begin
                if (strb[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
            end
        end
    endtask

    // Accept the B response and compare it against the scoreboard.
    task automatic do_b();
        int n = 0;
        logic [9:0] e;
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 50) begin step(); n++; end
        chk("bvalid", bus.bvalid, 1'b1);
        e = bq.pop_front();
        chk("bid", bus.bid, e[9:2]);
        chk("bresp", bus.bresp, e[1:0]);
        step();
        bus.bready = 1'b0;
        exp_wr++;
        chk("wr_cnt", wr_burst_cnt, CW'(exp_wr));
    endtask

    // Run a full write burst.
    // lastpos < 0 drives a correct wlast; otherwise wlast is driven only on
    // beat index lastpos.
    task automatic do_write(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int lastpos, input int seed, input logic [63:0] strb);
        bit any_oor = 1'b0;
        int idx;
        bit oor;
        for (int b = 0; b <= int'(len); b++) begin
            idx_of(addr, b, idx, oor);
            if (oor) any_oor = 1'b1;
        end
        bq.push_back({id, any_oor ? 2'b10 : 2'b00});
        if (lastpos >= 0 && lastpos != int'(len)) exp_proto = 1'b1;
        do_aw(id, addr, len);
        for (int b = 0; b <= int'(len); b++) begin
            do_wbeat(addr, b, pat(seed, b), strb,
                     (lastpos < 0) ? (b == int'(len)) : (b == lastpos));
            chk("bvalid_timing", bus.bvalid, (b == int'(len)));
        end
        do_b();
        chk("proto_err", proto_err, exp_proto);
    endtask

    // Present an AR request and complete its handshake.
    task automatic do_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin step(); n++; end
        chk("arready", bus.arready, 1'b1);
        step();
        bus.arvalid = 1'b0;
    endtask

    // Run a read burst. With bp set, rready toggles randomly and stall
    // stability is checked; otherwise latency and back-to-back beats are
    // checked.
    task automatic do_read(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input bit bp);
        int           idx;
        bit           oor;
        rd_entry_t    e;
        int           got     = 0;
        int           cyc     = 0;
        int           first   = -1;
        int           gaps    = 0;
        bit           stalled = 1'b0;
        logic [511:0] hd;
        logic [10:0]  hc;
        for (int b = 0; b <= int'(len); b++) begin
            idx_of(addr, b, idx, oor);
            e.data = oor ? 512'd0 : model[idx];
            e.resp = oor ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            rq.push_back(e);
        end
        bus.rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        do_ar(id, addr, len);
        while (got <= int'(len) && cyc < 2000) begin
            if (bus.rvalid) begin
                if (first < 0) first = cyc;
                if (bus.rready) begin
                    e = rq.pop_front();
                    chk("rdata", bus.rdata, e.data);
                    chk("rid", bus.rid, id);
                    chk("rresp", bus.rresp, e.resp);
                    chk("rlast", bus.rlast, e.last);
                    got++;
                end else begin
                    stalled = 1'b1;
                    hd = bus.rdata;
                    hc = {bus.rid, bus.rresp, bus.rlast};
                end
            end else if (first >= 0) begin
                gaps++;
            end
            step();
            cyc++;
            if (stalled) begin
                chk("r_hold_valid", bus.rvalid, 1'b1);
                chk("r_hold_data", bus.rdata, hd);
                chk("r_hold_ctl", {bus.rid, bus.rresp, bus.rlast}, hc);
                stalled = 1'b0;
            end
            if (bp) bus.rready = 1'($urandom_range(0, 1));
        end
        bus.rready = 1'b0;
        chk("r_beats", got, int'(len) + 1);
        if (!bp) begin
            chk("r_first_lat", first, 2);
            chk("r_gaps", gaps, 0);
        end
        exp_rd++;
        chk("rd_cnt", rd_burst_cnt, CW'(exp_rd));
        chk("arready_back", bus.arready, 1'b1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 512'd0;
        rst = 1'b1;
        bus.awid = 8'd0; bus.awaddr = 64'd0; bus.awlen = 8'd0; bus.awsize = 3'd6; bus.awvalid = 1'b0;
        bus.wid = 8'd0; bus.wdata = 512'd0; bus.wstrb = 64'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = 8'd0; bus.araddr = 64'd0; bus.arlen = 8'd0; bus.arsize = 3'd6; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        step(); step(); step();
        chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast, proto_err}, 4'b0000);
        chk("rst_cnt", {wr_burst_cnt, rd_burst_cnt}, 64'd0);
        rst = 1'b0;
        step();

        // Single beat write then read.
        do_write(8'h12, 64'h40, 8'd0, -1, 0, {64{1'b1}});
        do_read(8'h34, 64'h40, 8'd0, 1'b0);

        // Full-throughput read of 16 preloaded beats, then the same burst
        // under random backpressure.
        do_write(8'h01, 64'h1000, 8'd15, -1, 17, {64{1'b1}});
        do_read(8'h02, 64'h1000, 8'd15, 1'b0);
        do_read(8'h03, 64'h1000, 8'd15, 1'b1);

        // Byte strobes: only bytes 0-7 change.
        do_write(8'h21, 64'h8000, 8'd0, -1, 50, {64{1'b1}});
        do_write(8'h22, 64'h8000, 8'd0, -1, 90, 64'h0000_0000_0000_00FF);
        do_read(8'h23, 64'h8000, 8'd0, 1'b0);

        // Early wlast on a len=3 burst: 4 beats still required, proto_err set.
        do_write(8'h31, 64'h9000, 8'd3, 2, 60, {64{1'b1}});
        do_read(8'h32, 64'h9000, 8'd3, 1'b0);

        // First index past the end of the RAM.
        do_write(8'h41, 64'(DEPTH) * 64'd64, 8'd0, -1, 70, {64{1'b1}});
        do_read(8'h42, 64'(DEPTH) * 64'd64, 8'd0, 1'b0);
`ifndef AXI_MEM_RESP_ERR_EN
        do_read(8'h43, 64'h0, 8'd0, 1'b0);
`endif

        // Reset in the middle of beat 5 of a len=7 write.
        do_aw(8'h77, 64'h2000, 8'd7);
        for (int b = 0; b < 4; b++) do_wbeat(64'h2000, b, pat(7, b), {64{1'b1}}, 1'b0);
        bus.wdata = pat(7, 4); bus.wstrb = {64{1'b1}}; bus.wvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("mid_rst_valid", {bus.bvalid, bus.rvalid, bus.rlast, proto_err}, 4'b0000);
        chk("mid_rst_cnt", {wr_burst_cnt, rd_burst_cnt}, 64'd0);
        bus.wvalid = 1'b0;
        step(); step();
        rst = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_proto = 1'b0;
        bq.delete();
        do_write(8'h5A, 64'h3000, 8'd1, -1, 9, {64{1'b1}});
        do_read(8'h5B, 64'h3000, 8'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 responder (subordinate) for the DRAM-perf custom logic. Terminates the responder end of an axi_bus_t link driven by a traffic initiator, and backs it with an on-chip 512-bit-wide RAM.
- Gives the initiator and perf counters a DDR-free target with deterministic latency, for bring-up and for baselining.
- Write and read channels are independent. Each accepts one burst at a time and completes in order.

Parameters:
- MEM_DEPTH, 1024, RAM depth in 64-byte beats; power of two.
- CNT_W, 32, width of the burst counters.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous active-high reset.
- axi  interface  axi_bus_t.master  responder side: aw*/w*/ar*/bready/rready in; awready/wready/b*/arready/r* out.
- wr_burst_cnt  output  CNT_W  completed write bursts (counted on B handshake); wraps.
- rd_burst_cnt  output  CNT_W  completed read bursts (counted on rlast handshake); wraps.
- proto_err  output  1  sticky: wlast disagreed with awlen.

Behaviour:
- Reset: all outputs 0 (awready, wready, bvalid, arready, rvalid, rlast, counters, proto_err). FSMs return to idle. RAM contents are not cleared. Reset mid-burst abandons the burst silently.
- Bursts are INCR only. Beat size is fixed at 64 B; awsize/arsize are ignored. wid is ignored.
- RAM index = addr[63:6] + beat, modulo MEM_DEPTH.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, register awid/awaddr/awlen, awready->0 next cycle, go W_DATA.
  - W_DATA: wready=1. Each W handshake writes the beat with per-byte wstrb enables and increments the beat counter.
  - Beat count is authoritative. On beat awlen+1, go W_RESP regardless of wlast.
  - wlast=1 on any earlier beat, or wlast=0 on the final beat, sets proto_err.
  - W_RESP: bvalid=1, bid=captured awid, bresp=OKAY. Hold until bready, then go W_IDLE; wr_burst_cnt+1.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, register arid/araddr/arlen, go R_DATA.
  - R_DATA: RAM reads are issued into a 2-entry output FIFO while (occupancy + reads in flight) < 2. RAM read latency is 1 cycle.
  - rvalid = FIFO non-empty. rid=captured arid, rresp=OKAY, rlast on beat arlen.
  - First rvalid appears 2 cycles after the AR handshake. Sustained rate is 1 beat/cycle with rready=1.
  - r* are held stable while rvalid && !rready.
  - After the rlast handshake: rd_burst_cnt+1, go R_IDLE. arready rises the next cycle.
- RAM is simple dual-port (write port + read port). A same-cycle read and write to the same index returns old data (read-first).
- Simultaneous AW and AR handshakes in one cycle are both accepted.
- Beat counters are 8-bit, matching awlen/arlen; len=255 gives 256 beats.

Optional Feature:
- Macro AXI_MEM_RESP_ERR_EN.
- Defined:
  - A beat whose full index (addr[63:6] + beat) is >= MEM_DEPTH is out of range.
  - Out-of-range write beats are dropped, and bresp=SLVERR (2'b10) if any beat of the burst was out of range.
  - Out-of-range read beats return rdata=0 and rresp=SLVERR on that beat only.
  - No wrap.
- Undefined: modulo wrap as above; bresp/rresp are always OKAY.

Decomposition:
- Package axi_mem_resp_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - BEAT_BYTES=64, BEAT_LSB=6.
  - Write and read FSM state enums.
  - Read-FIFO entry struct {data[511:0], resp[1:0], last}.
- One sub-module: axi_mem_resp_fifo2, the 2-entry output FIFO feeding the R channel, with count output for the issue credit check.

Test Plan:
- Single beat, write then read: AW id=0x12, addr=0x40, len=0; W data=incrementing bytes, wstrb=all-ones, wlast=1.
  - Required: bvalid 1 cycle after the W handshake, bid=0x12, bresp=0.
  - Then AR id=0x34, addr=0x40, len=0. Required: rdata identical, rid=0x34, rlast=1, wr_burst_cnt=1, rd_burst_cnt=1.
- Full-throughput read: preload 16 beats, then AR len=15 with rready=1.
  - Required: first rvalid 2 cycles after AR, then 16 consecutive rvalid cycles, rlast only on the 16th.
- Backpressure: same burst with rready randomly toggled.
  - Required: beats in order, no loss or duplication, r* stable while stalled.
- Strobes and wlast errors:
  - Write wstrb=0x00000000000000FF over known data. Required: only bytes 0-7 change.
  - len=3 with wlast on beat 2. Required: proto_err=1, bvalid only after 4 W beats.
- Boundary and reset:
  - addr = MEM_DEPTH*64, len=0. With AXI_MEM_RESP_ERR_EN: bresp=2'b10, rresp=2'b10, rdata=0. Without: aliases index 0.
  - Assert rst during beat 5 of a len=7 write. Required: all valids/readys 0, then a fresh AW is accepted after release.
